instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//  Registered MIPS32 instruction field splitter/classifier for the single-cycle-ish CPU.
//  Sits between instruction memory and register file/control; slices instr into
//  R/I/J fields, classifies format, sign-extends imm16, flags unsupported encodings.
//  All outputs registered: one clk of latency from instr to fields.
// PARAMETERS
//  none (MIPS32 field layout is fixed)
// PORTS
//  clk       in   1   system clock, rising-edge active
//  reset     in   1   synchronous, active-high reset
//  instr     in   32  instruction word from instruction memory
//  opcode    out  6   instr[31:26]
//  rs        out  5   instr[25:21]
//  rt        out  5   instr[20:16]
//  rd        out  5   instr[15:11]
//  shamt     out  5   instr[10:6]
//  funct     out  6   instr[5:0]
//  imm16     out  16  instr[15:0]
//  address   out  26  instr[25:0] (jump target field)
//  imm32     out  32  {{16{instr[15]}},instr[15:0]} sign-extended immediate
//  fmt       out  2   00=R (opcode 0), 10=J (opcode 02/03), 01=I (all others)
//  illegal   out  1   1 = encoding outside supported set
// BEHAVIOUR
//  - One clock, single domain; reset is synchronous and active-high.
//  - Reset: on rising clk with reset=1, every output <= 0 (fmt=00, illegal=0);
//    reset dominates instr.
//  - Otherwise each rising clk: all outputs <= decode(instr); hold until next edge.
//  - Latency exactly 1 cycle; no handshake, no enable, no stall; new instr every cycle.
//  - Field slices are unconditional: all fields driven regardless of format.
//  - Supported set (illegal=0): opcode 00 with funct 20 add, 22 sub, 2A slt, 08 jr;
//    opcode 02 j, 03 jal, 04 beq, 05 bne, 08 addi, 0E xori, 23 lw, 2B sw.
//    Any other opcode, or opcode 00 with other funct -> illegal=1.
//  - NOP (32'h0) = sll $0,$0,0: fields all 0, fmt=00, illegal=0 (special-cased legal).
//  - X/Z on instr is not required to be handled; outputs follow bits.
// TESTING
//  1 reset=1 for 2 clks, instr=32'hFFFFFFFF -> all outputs 0.
//  2 instr=32'h00000000 -> next edge: opcode=0, funct=0, fmt=00, illegal=0.
//  3 instr=32'h01782020 (add $4,$11,$24) -> opcode=00 rs=11 rt=24 rd=4 shamt=0
//    funct=20 imm16=2020 address=1782020 fmt=00 illegal=0; 1-cycle latency checked.
//  4 instr=32'h2108FFFF (addi $8,$8,-1) -> opcode=08 rs=8 rt=8 imm16=FFFF
//    imm32=FFFFFFFF fmt=01 illegal=0.
//  5 instr=32'h0C000010 (jal) -> opcode=03 address=0000010 fmt=10 illegal=0;
//    instr=32'hFC000000 -> illegal=1; instr=32'h00000021 -> illegal=1.
//  6 assert reset mid-stream with valid instr -> outputs 0 at that edge, resume next.

Source files
------------

// File: rtl/instruction_decode.sv
// Registered MIPS32 instruction splitter: slices R/I/J fields, classifies the
// format, sign-extends imm16 and flags encodings outside the supported subset.
module instruction_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] address,
   output logic [31:0] imm32,
   output logic [1:0]  fmt,
   output logic        illegal
);

   localparam int unsigned OP_W  = 6;
   localparam int unsigned FMT_W = 2;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [OP_W-1:0] FN_JR    = 6'h08;
   localparam logic [OP_W-1:0] FN_ADD   = 6'h20;
   localparam logic [OP_W-1:0] FN_SUB   = 6'h22;
   localparam logic [OP_W-1:0] FN_SLT   = 6'h2A;

   localparam logic [FMT_W-1:0] FMT_R = 2'b00;
   localparam logic [FMT_W-1:0] FMT_I = 2'b01;
   localparam logic [FMT_W-1:0] FMT_J = 2'b10;

   logic [OP_W-1:0]  op_c;
   logic [OP_W-1:0]  fn_c;
   logic [FMT_W-1:0] fmt_c;
   logic             illegal_c;

   assign op_c = instr[31:26];
   assign fn_c = instr[5:0];

   // Format class and supported-set check; the all-zero NOP is legal on its own.
   always_comb begin
      fmt_c     = FMT_I;
      illegal_c = 1'b1;
      case (op_c)
         OP_RTYPE: begin
            fmt_c = FMT_R;
            case (fn_c)
               FN_ADD, FN_SUB, FN_SLT, FN_JR: illegal_c = 1'b0;
               default:                       illegal_c = (instr != 32'h0000_0000);
            endcase
         end
         OP_J, OP_JAL: begin
            fmt_c     = FMT_J;
            illegal_c = 1'b0;
         end
         OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: illegal_c = 1'b0;
         default: illegal_c = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opcode  <= '0;
         rs      <= '0;
         rt      <= '0;
         rd      <= '0;
         shamt   <= '0;
         funct   <= '0;
         imm16   <= '0;
         address <= '0;
         imm32   <= '0;
         fmt     <= FMT_R;
         illegal <= 1'b0;
      end else begin
         opcode  <= op_c;
         rs      <= instr[25:21];
         rt      <= instr[20:16];
         rd      <= instr[15:11];
         shamt   <= instr[10:6];
         funct   <= fn_c;
         imm16   <= instr[15:0];
         address <= instr[25:0];
         imm32   <= {{16{instr[15]}}, instr[15:0]};
         fmt     <= fmt_c;
         illegal <= illegal_c;
      end
   end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: hand-decoded vectors checked one
// cycle after each instruction is applied.
module tb_instruction_decode;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [25:0] address;
   logic [31:0] imm32;
   logic [1:0]  fmt;
   logic        illegal;

   int errors = 0;
   int checks = 0;

   instruction_decode dut (
      .clk     (clk),
      .reset   (reset),
      .instr   (instr),
      .opcode  (opcode),
      .rs      (rs),
      .rt      (rt),
      .rd      (rd),
      .shamt   (shamt),
      .funct   (funct),
      .imm16   (imm16),
      .address (address),
      .imm32   (imm32),
      .fmt     (fmt),
      .illegal (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag,
                          input logic [5:0] e_op, input logic [4:0] e_rs,
                          input logic [4:0] e_rt, input logic [4:0] e_rd,
                          input logic [4:0] e_sh, input logic [5:0] e_fn,
                          input logic [15:0] e_imm16, input logic [25:0] e_addr,
                          input logic [31:0] e_imm32, input logic [1:0] e_fmt,
                          input logic e_ill);
      chk({tag, ".opcode"},  32'(opcode),  32'(e_op));
      chk({tag, ".rs"},      32'(rs),      32'(e_rs));
      chk({tag, ".rt"},      32'(rt),      32'(e_rt));
      chk({tag, ".rd"},      32'(rd),      32'(e_rd));
      chk({tag, ".shamt"},   32'(shamt),   32'(e_sh));
      chk({tag, ".funct"},   32'(funct),   32'(e_fn));
      chk({tag, ".imm16"},   32'(imm16),   32'(e_imm16));
      chk({tag, ".address"}, 32'(address), 32'(e_addr));
      chk({tag, ".imm32"},   imm32,        e_imm32);
      chk({tag, ".fmt"},     32'(fmt),     32'(e_fmt));
      chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
   endtask

   // Apply at the falling edge, then sample 1 time unit after the next rising edge.
   task automatic apply(input logic r, input logic [31:0] v);
      @(negedge clk);
      reset = r;
      instr = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      instr = 32'hFFFF_FFFF;

      // Reset held two clocks with all-ones instruction
      @(posedge clk);
      apply(1'b1, 32'hFFFF_FFFF);
      chk_all("reset", 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000,
              26'h0000000, 32'h0000_0000, 2'b00, 1'b0);

      // NOP
      apply(1'b0, 32'h0000_0000);
      chk_all("nop", 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000,
              26'h0000000, 32'h0000_0000, 2'b00, 1'b0);

      // add: outputs must still hold NOP before the edge
      @(negedge clk);
      instr = 32'h0178_2020;
      #1;
      chk("add.latency_rd", 32'(rd), 32'd0);
      chk("add.latency_funct", 32'(funct), 32'h00);
      @(posedge clk);
      #1;
      chk_all("add", 6'h00, 5'd11, 5'd24, 5'd4, 5'd0, 6'h20, 16'h2020,
              26'h1782020, 32'h0000_2020, 2'b00, 1'b0);

      // addi $8,$8,-1: negative sign extension
      apply(1'b0, 32'h2108_FFFF);
      chk_all("addi", 6'h08, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF,
              26'h108FFFF, 32'hFFFF_FFFF, 2'b01, 1'b0);

      // jal
      apply(1'b0, 32'h0C00_0010);
      chk_all("jal", 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10, 16'h0010,
              26'h0000010, 32'h0000_0010, 2'b10, 1'b0);

      // unsupported opcode 3F
      apply(1'b0, 32'hFC00_0000);
      chk_all("op3f", 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000,
              26'h0000000, 32'h0000_0000, 2'b01, 1'b1);

      // R-type with unsupported funct 21
      apply(1'b0, 32'h0000_0021);
      chk_all("fn21", 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h21, 16'h0021,
              26'h0000021, 32'h0000_0021, 2'b00, 1'b1);

      // sll $0,$0,1 is not the NOP word, so it is unsupported
      apply(1'b0, 32'h0000_0040);
      chk_all("sll1", 6'h00, 5'd0, 5'd0, 5'd0, 5'd1, 6'h00, 16'h0040,
              26'h0000040, 32'h0000_0040, 2'b00, 1'b1);

      // sub $10,$8,$9: positive sign extension
      apply(1'b0, 32'h0109_5022);
      chk_all("sub", 6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h22, 16'h5022,
              26'h1095022, 32'h0000_5022, 2'b00, 1'b0);

      // reset mid-stream dominates a valid instruction, then decode resumes
      apply(1'b1, 32'h2108_FFFF);
      chk_all("midreset", 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000,
              26'h0000000, 32'h0000_0000, 2'b00, 1'b0);
      apply(1'b0, 32'h2108_FFFF);
      chk_all("resume", 6'h08, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF,
              26'h108FFFF, 32'hFFFF_FFFF, 2'b01, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
